// File: rtl/vslc_pkg.sv
// vslc_pkg: shared widths and direction constants for the VSLC blocks
package vslc_pkg;
  localparam int VSLC_TIMER_WIDTH = 10;
  localparam logic VSLC_DIR_DOWN = 1'b0;
  localparam logic VSLC_DIR_UP = 1'b1;
endpackage

// File: rtl/tt_um_jimktrains_vslc_edge_detect.sv
// tt_um_jimktrains_vslc_edge_detect: rising-edge strobe from a registered history bit
module tt_um_jimktrains_vslc_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_rise
);
  logic r_prev;
  always_ff @(posedge clk) r_prev <= rst ? 1'b0 : i_in;
  assign o_rise = i_in & ~r_prev;
endmodule

// File: rtl/tt_um_jimktrains_vslc_counter.sv
// tt_um_jimktrains_vslc_counter: saturating up/down event counter with preset compare
module tt_um_jimktrains_vslc_counter
  import vslc_pkg::*;
#(
  parameter int WIDTH = VSLC_TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_enabled,
  input  logic             count_in,
  input  logic             count_up,
  input  logic [WIDTH-1:0] preset,
  input  logic             load,
  output logic [WIDTH-1:0] counter_o,
  output logic             done,
  output logic             overflow,
  output logic             edge_o
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] r_counter, w_next;
  logic r_done, r_overflow, w_ovf_next, w_edge, w_up, w_sat;
  tt_um_jimktrains_vslc_edge_detect u_edge (
    .clk(clk),
    .rst(rst),
    .i_in(count_in),
    .o_rise(w_edge)
  );
  assign w_up = count_up == VSLC_DIR_UP;
  assign w_sat = w_up ? r_counter == MAX : r_counter == '0;
  // saturation holds the count and flags overflow instead of wrapping
  always_comb begin
    w_next = r_counter;
    w_ovf_next = r_overflow;
    if (load) begin
      w_next = w_up ? '0 : preset;
      w_ovf_next = 1'b0;
    end else if (count_enabled && w_edge) begin
      w_next = w_sat ? r_counter : (w_up ? r_counter + 1'b1 : r_counter - 1'b1);
      w_ovf_next = r_overflow | w_sat;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_counter <= '0;
      r_overflow <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_counter <= w_next;
      r_overflow <= w_ovf_next;
      r_done <= w_up ? w_next >= preset : w_next == '0;
    end
  end
  assign counter_o = r_counter;
  assign done = r_done;
  assign overflow = r_overflow;
  assign edge_o = w_edge;
endmodule
